// File: rtl/alu_ctrl_4.sv
// alu_ctrl_4: four-state controller that reads two operands from an external
// 4x4 register file, applies ADD/SUB/AND/OR, and writes the result back.
// One instruction every four cycles; the write commits three edges after accept.
module alu_ctrl_4 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic [1:0] i_opcode,
    input  logic [1:0] i_rs0,
    input  logic [1:0] i_rs1,
    input  logic [1:0] i_rd,
    output logic       o_ready,
    output logic [1:0] o_reg_read_0,
    output logic [1:0] o_reg_read_1,
    input  logic [3:0] i_port_read_0,
    input  logic [3:0] i_port_read_1,
    output logic [1:0] o_reg_write,
    output logic [3:0] o_port_write,
    output logic       o_write_enable,
    output logic       o_done,
    output logic       o_zero,
    output logic       o_carry
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } opcode_t;

    state_t     state;
    state_t     state_next;
    opcode_t    opcode_q;
    logic [1:0] rd_q;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic       accept;
    logic [3:0] alu_result;
    logic       alu_carry;

    assign accept = i_valid && (state == IDLE);

    // State register; reset lands in IDLE asynchronously so a WRITE in flight is dropped.
    // NOTE: sequential blocks use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic: only IDLE waits; the other states advance every edge.
    // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_valid) state_next = READ;
            READ:    state_next = EXEC;
            EXEC:    state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs decoded straight from the state so reset clears them immediately.
    assign o_ready        = (state == IDLE);
    assign o_write_enable = (state == WRITE);
    assign o_done         = (state == WRITE);

    // ALU: 5-bit add/subtract exposes carry (or no-borrow) in bit 4; logic ops clear it.
    always_comb begin
        logic [4:0] wide;
        wide       = 5'd0;
        alu_result = 4'd0;
        alu_carry  = 1'b0;
        case (opcode_q)
            OP_ADD: begin
                wide       = {1'b0, a_q} + {1'b0, b_q};
                alu_result = wide[3:0];
                alu_carry  = wide[4];
            end
            OP_SUB: begin
                wide       = {1'b0, a_q} + {1'b0, ~b_q} + 5'd1;
                alu_result = wide[3:0];
                alu_carry  = wide[4];
            end
            OP_AND:  alu_result = a_q & b_q;
            OP_OR:   alu_result = a_q | b_q;
            default: alu_result = 4'd0;
        endcase
    end

    // Accept: latch the instruction; read addresses are driven from here and hold until the next accept.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            opcode_q     <= OP_ADD;
            rd_q         <= 2'd0;
            o_reg_read_0 <= 2'd0;
            o_reg_read_1 <= 2'd0;
        end else if (accept) begin
            opcode_q     <= opcode_t'(i_opcode);
            rd_q         <= i_rd;
            o_reg_read_0 <= i_rs0;
            o_reg_read_1 <= i_rs1;
        end
    end

    // End of READ: capture operands, so a later write to rd cannot disturb them.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_q <= 4'd0;
            b_q <= 4'd0;
        end else if (state == READ) begin
            a_q <= i_port_read_0;
            b_q <= i_port_read_1;
        end
    end

    // End of EXEC: register result, write address and flags; all hold until the next EXEC.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_reg_write  <= 2'd0;
            o_port_write <= 4'd0;
            o_zero       <= 1'b0;
            o_carry      <= 1'b0;
        end else if (state == EXEC) begin
            o_reg_write  <= rd_q;
            o_port_write <= alu_result;
            o_zero       <= (alu_result == 4'd0);
            o_carry      <= alu_carry;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_4.sv
// tb_alu_ctrl_4: drives alu_ctrl_4 against a behavioural 4x4 register file.
// Expected writes are pushed to a queue at accept and popped when o_done rises.
module tb_alu_ctrl_4;

    typedef struct packed {
        logic [1:0] rd;
        logic [3:0] result;
        logic       zero;
        logic       carry;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [1:0] opcode, rs0, rs1, rd;
    logic       ready;
    logic [1:0] reg_read_0, reg_read_1, reg_write;
    logic [3:0] port_read_0, port_read_1, port_write;
    logic       write_enable, done, zero, carry;

    logic [3:0] rf [4];
    logic       pre_en;
    logic [1:0] pre_addr;
    logic [3:0] pre_data;

    logic [3:0] model_rf [4];
    exp_t       exp_q [$];
    exp_t       last_exp;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    alu_ctrl_4 dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_valid        (valid),
        .i_opcode       (opcode),
        .i_rs0          (rs0),
        .i_rs1          (rs1),
        .i_rd           (rd),
        .o_ready        (ready),
        .o_reg_read_0   (reg_read_0),
        .o_reg_read_1   (reg_read_1),
        .i_port_read_0  (port_read_0),
        .i_port_read_1  (port_read_1),
        .o_reg_write    (reg_write),
        .o_port_write   (port_write),
        .o_write_enable (write_enable),
        .o_done         (done),
        .o_zero         (zero),
        .o_carry        (carry)
    );

    // Register file: combinational read, write on rising edge, plus a bench preload port.
    assign port_read_0 = rf[reg_read_0];
    assign port_read_1 = rf[reg_read_1];
    always @(posedge clk) begin
        if (write_enable) rf[reg_write] <= port_write;
        if (pre_en)       rf[pre_addr]  <= pre_data;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                                   input logic [1:0] dst);
        exp_t       e;
        logic [4:0] w;
        w = 5'd0;
        case (op)
            2'b00: w = {1'b0, a} + {1'b0, b};
            2'b01: w = {1'b0, a} - {1'b0, b} + 5'd16; // bit 4 set when no borrow
            2'b10: w = {1'b0, a & b};
            default: w = {1'b0, a | b};
        endcase
        e.rd     = dst;
        e.result = w[3:0];
        e.carry  = (op == 2'b00 || op == 2'b01) ? w[4] : 1'b0;
        e.zero   = (w[3:0] == 4'd0);
        return e;
    endfunction

    // Push expected result at accept and update the bench register model.
    task automatic push_exp(input logic [1:0] op, input logic [1:0] d, input logic [1:0] s0,
                            input logic [1:0] s1);
        exp_t e;
        e = model(op, model_rf[s0], model_rf[s1], d);
        exp_q.push_back(e);
        model_rf[d] = e.result;
        last_exp    = e;
    endtask

    // Scoreboard: in every WRITE cycle compare the write port and flags with the queue head.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 8'(done), 8'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_we",    8'(write_enable), 8'd1);
                check("sb_waddr", 8'(reg_write),    8'(e.rd));
                check("sb_wdata", 8'(port_write),   8'(e.result));
                check("sb_zero",  8'(zero),         8'(e.zero));
                check("sb_carry", 8'(carry),        8'(e.carry));
            end
        end
    end

    task automatic preload(input logic [1:0] a, input logic [3:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk);
        #1 pre_en = 1'b0;
        model_rf[a] = d;
    endtask

    // Issue one instruction, wait for acceptance, and check latency and read addresses.
    task automatic issue(input logic [1:0] op, input logic [1:0] d, input logic [1:0] s0,
                         input logic [1:0] s1);
        int n;
        @(negedge clk);
        opcode = op; rd = d; rs0 = s0; rs1 = s1; valid = 1'b1;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("accept_timeout", 8'(ready), 8'd1);
        @(posedge clk);
        push_exp(op, d, s0, s1);
        #1 valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("read_addr0", 8'(reg_read_0), 8'(s0));
                check("read_addr1", 8'(reg_read_1), 8'(s1));
                check("busy_ready", 8'(ready),      8'd0);
            end
        end while (!done && n < 10);
        check("latency", 8'(n), 8'd3);
        @(posedge clk);
        #1;
        check("rf_commit",  8'(rf[d]), 8'(model_rf[d]));
        check("ready_back", 8'(ready),  8'd1);
        check("zero_hold",  8'(zero),   8'(last_exp.zero));
        check("carry_hold", 8'(carry),  8'(last_exp.carry));
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; opcode = 2'd0; rs0 = 2'd0; rs1 = 2'd0; rd = 2'd0;
        pre_en = 1'b0; pre_addr = 2'd0; pre_data = 4'd0;
        for (int i = 0; i < 4; i++) model_rf[i] = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 8'(ready),        8'd1);
        check("rst_we",    8'(write_enable), 8'd0);
        check("rst_done",  8'(done),         8'd0);
        check("rst_zero",  8'(zero),         8'd0);
        check("rst_carry", 8'(carry),        8'd0);
        check("rst_raddr", 8'({reg_read_0, reg_read_1}), 8'd0);
        check("rst_waddr", 8'(reg_write),    8'd0);
        check("rst_wdata", 8'(port_write),   8'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) preload(2'(i), 4'd0);

        // Basic add: 5 + 3 = 8.
        preload(2'd1, 4'b0101); preload(2'd2, 4'b0011);
        issue(2'b00, 2'd3, 2'd1, 2'd2);
        check("r3_add", 8'(rf[3]), 8'h08);

        // Add overflow and self-subtract both yield zero with carry.
        preload(2'd1, 4'b1111); preload(2'd2, 4'b0001);
        issue(2'b00, 2'd0, 2'd1, 2'd2);
        check("r0_ovf", 8'({carry, zero, rf[0]}), 8'h30);
        issue(2'b01, 2'd0, 2'd1, 2'd1);
        check("r0_sub0", 8'({carry, zero, rf[0]}), 8'h30);

        // Borrowing subtract, AND, OR.
        preload(2'd1, 4'b0011); preload(2'd2, 4'b0101);
        issue(2'b01, 2'd3, 2'd1, 2'd2);
        check("r3_sub", 8'({carry, rf[3]}), 8'h0e);
        issue(2'b10, 2'd0, 2'd1, 2'd2);
        check("r0_and", 8'({carry, rf[0]}), 8'h01);
        issue(2'b11, 2'd0, 2'd1, 2'd2);
        check("r0_or",  8'({carry, rf[0]}), 8'h07);

        // rd equals source: pre-write operand values are used (3+3).
        issue(2'b00, 2'd1, 2'd1, 2'd1);
        check("r1_self", 8'(rf[1]), 8'h06);

        // Held valid: second instruction waits for ready and sees the new r0.
        preload(2'd1, 4'b0011);
        @(negedge clk);
        opcode = 2'b00; rd = 2'd0; rs0 = 2'd1; rs1 = 2'd1; valid = 1'b1;
        @(posedge clk);
        push_exp(2'b00, 2'd0, 2'd1, 2'd1);
        #1 rd = 2'd2; rs0 = 2'd0; rs1 = 2'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("held_busy", 8'(ready), 8'd0);
        end
        @(negedge clk);
        check("held_ready", 8'(ready), 8'd1);
        @(posedge clk);
        push_exp(2'b00, 2'd2, 2'd0, 2'd0);
        #1 valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("held_r0", 8'(rf[0]), 8'h06);
        check("held_r2", 8'(rf[2]), 8'h0c);
        check("held_sb_empty", 8'(exp_q.size()), 8'd0);

        // Randomised instructions through the scoreboard.
        for (int k = 0; k < 12; k++)
            issue(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));

        // Reset during WRITE aborts the write.
        preload(2'd3, 4'b1111); preload(2'd1, 4'b0001); preload(2'd2, 4'b0001);
        @(negedge clk);
        opcode = 2'b00; rd = 2'd3; rs0 = 2'd1; rs1 = 2'd2; valid = 1'b1;
        @(posedge clk);
        push_exp(2'b00, 2'd3, 2'd1, 2'd2);
        model_rf[3] = 4'b1111;
        #1 valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("pre_abort_we", 8'(write_enable), 8'd1);
        rst = 1'b1;
        #1;
        check("abort_we",    8'(write_enable), 8'd0);
        check("abort_ready", 8'(ready),        8'd1);
        check("abort_done",  8'(done),         8'd0);
        check("abort_wdata", 8'(port_write),   8'd0);
        check("abort_flags", 8'({zero, carry}), 8'd0);
        @(posedge clk);
        #1;
        check("abort_r3", 8'(rf[3]), 8'h0f);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) model_rf[i] = rf[i];

        // First instruction after reset is accepted on its first valid edge.
        issue(2'b01, 2'd0, 2'd3, 2'd1);
        check("post_rst_r0", 8'(rf[0]), 8'h0e);
        check("sb_drained",  8'(exp_q.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
